// File: rtl/mem_ctrl.sv
// CPU-side memory controller: 256x8 RAM with run-mode read/write handshake and program-load port.
// Optional MEM_WAIT_EN adds one wait state between access and completion.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpustate,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  rdata,
    output logic        ready,
    input  logic [7:0]  ld_data,
    input  logic        ld_stb,
    output logic [7:0]  ld_addr,
    output logic        err
);

`ifdef MEM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
`endif

    localparam logic [1:0] CS_LOAD = 2'b01;
    localparam logic [1:0] CS_RUN  = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  acc_addr_q, acc_addr_d;
    logic [7:0]  acc_wdata_q, acc_wdata_d;
    logic        acc_rd_q, acc_rd_d;
    logic        acc_wr_q, acc_wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  ld_addr_q, ld_addr_d;
    logic        err_q, err_d;
    logic [1:0]  cs_q;

    logic [7:0]  mem [256];
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        load_entry;
    logic [7:0]  ld_base;

    // Entering load mode restarts the load pointer in the same cycle a strobe may use it.
    assign load_entry = (cpustate == CS_LOAD) && (cs_q != CS_LOAD);
    assign ld_base    = load_entry ? 8'h00 : ld_addr_q;

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        acc_rd_d    = acc_rd_q;
        acc_wr_d    = acc_wr_q;
        rdata_d     = rdata_q;
        ld_addr_d   = ld_base;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = 8'h00;
        mem_wdata   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (cpustate == CS_RUN && (read || write)) begin
                    acc_addr_d  = addr[7:0];
                    acc_wdata_d = wdata;
                    acc_rd_d    = read;
                    acc_wr_d    = write;
                    if ((read && write) || (addr[15:8] != 8'h00)) begin
                        err_d = 1'b1;
                    end
                    state_d = S_ACC;
                end else if (cpustate == CS_LOAD && ld_stb) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_base;
                    mem_wdata = ld_data;
                    ld_addr_d = ld_base + 8'd1;
                end
            end
            S_ACC: begin
                // A simultaneous read+write is a protocol error: no memory side effects at all.
                if (acc_wr_q && !acc_rd_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = acc_addr_q;
                    mem_wdata = acc_wdata_q;
                end else if (acc_rd_q && !acc_wr_q) begin
                    rdata_d = mem[acc_addr_q];
                end
`ifdef MEM_WAIT_EN
                state_d = S_WAIT;
`else
                state_d = S_DONE;
`endif
            end
`ifdef MEM_WAIT_EN
            S_WAIT:  state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_addr_q  <= 8'h00;
            acc_wdata_q <= 8'h00;
            acc_rd_q    <= 1'b0;
            acc_wr_q    <= 1'b0;
            rdata_q     <= 8'h00;
            ld_addr_q   <= 8'h00;
            err_q       <= 1'b0;
            cs_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            acc_rd_q    <= acc_rd_d;
            acc_wr_q    <= acc_wr_d;
            rdata_q     <= rdata_d;
            ld_addr_q   <= ld_addr_d;
            err_q       <= err_d;
            cs_q        <= cpustate;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory; its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = (state_q == S_DONE);
    assign ld_addr = ld_addr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: random run-mode traffic against an array model of the RAM.
module tb_mem_ctrl;

`ifdef MEM_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cpustate = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_stb = 1'b0;
    logic [7:0]  rdata;
    logic        ready;
    logic [7:0]  ld_addr;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] rdata_exp = 8'h00;
    logic [7:0] ld_exp = 8'h00;
    logic       err_exp = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .wdata(wdata),
        .read(read), .write(write), .rdata(rdata), .ready(ready),
        .ld_data(ld_data), .ld_stb(ld_stb), .ld_addr(ld_addr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic strobe(input logic [7:0] d);
        @(negedge clk);
        ld_data = d;
        ld_stb  = 1'b1;
        @(negedge clk);
        ld_stb  = 1'b0;
        ref_mem[ld_exp] = d;
        ld_exp = ld_exp + 8'd1;
    endtask

    // One run-mode transaction: request held for one sampling edge, then completion checked.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [7:0] d);
        int lat;
        @(negedge clk);
        read = rd; write = wr; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin read = 1'b0; write = 1'b0; end
        end while (ready !== 1'b1 && lat < 8);
        if ((rd && wr) || a[15:8] != 8'h00) err_exp = 1'b1;
        if (rd && !wr) rdata_exp = ref_mem[a[7:0]];
        else if (wr && !rd) ref_mem[a[7:0]] = d;
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, LAT);
        end
        checks++;
        if (rdata !== rdata_exp) begin
            failures++;
            $display("FAIL %s rdata: got %h expected %h", name, rdata, rdata_exp);
        end
        checks++;
        if (err !== err_exp) begin
            failures++;
            $display("FAIL %s err: got %b expected %b", name, err, err_exp);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_width: got %b expected 0", name, ready);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({rdata, ready, ld_addr, err} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdata=%h ready=%b ld_addr=%h err=%b expected all zero",
                     rdata, ready, ld_addr, err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load_basic();
        @(negedge clk);
        cpustate = 2'b01;
        strobe(8'hA5);
        strobe(8'h3C);
        checks++;
        if (ld_addr !== 8'h02) begin
            failures++;
            $display("FAIL load_basic ld_addr: got %h expected 02", ld_addr);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL load_basic ready: got %b expected 0", ready);
        end
        @(negedge clk);
        cpustate = 2'b10;
        access("load_basic_rd0", 1'b1, 1'b0, 16'h0000, 8'h00);
        checks++;
        if (rdata !== 8'hA5) begin
            failures++;
            $display("FAIL load_basic mem0: got %h expected a5", rdata);
        end
        access("load_basic_rd1", 1'b1, 1'b0, 16'h0001, 8'h00);
        checks++;
        if (rdata !== 8'h3C) begin
            failures++;
            $display("FAIL load_basic mem1: got %h expected 3c", rdata);
        end
    endtask

    task automatic test_load_wrap();
        @(negedge clk);
        cpustate = 2'b00;
        @(negedge clk);
        cpustate = 2'b01;
        ld_exp = 8'h00;
        @(negedge clk);
        checks++;
        if (ld_addr !== 8'h00) begin
            failures++;
            $display("FAIL load_entry_clear ld_addr: got %h expected 00", ld_addr);
        end
        for (int i = 0; i < 256; i++) strobe(8'($urandom));
        checks++;
        if (ld_addr !== 8'h00) begin
            failures++;
            $display("FAIL load_wrap ld_addr: got %h expected 00", ld_addr);
        end
        strobe(8'($urandom));
        checks++;
        if (ld_addr !== ld_exp) begin
            failures++;
            $display("FAIL load_257 ld_addr: got %h expected %h", ld_addr, ld_exp);
        end
        @(negedge clk);
        cpustate = 2'b10;
        access("load_257_rd0", 1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic test_random_rw();
        for (int i = 0; i < 30; i++) begin
            logic rd;
            rd = 1'($urandom);
            access("random_rw", rd, !rd, {8'h00, 8'($urandom_range(0, 15))}, 8'($urandom));
        end
        checks++;
        if (ld_addr !== ld_exp) begin
            failures++;
            $display("FAIL run_ld_addr_hold: got %h expected %h", ld_addr, ld_exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        a = 8'($urandom);
        @(negedge clk);
        read = 1'b1;
        addr = {8'h00, a};
        for (int i = 1; i <= 2 * LAT + 1; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== ((i == LAT) || (i == 2 * LAT + 1))) begin
                failures++;
                $display("FAIL back_to_back ready@%0d: got %b expected %b",
                         i, ready, (i == LAT) || (i == 2 * LAT + 1));
            end
            if (i == 2 * LAT + 1) read = 1'b0;
        end
        rdata_exp = ref_mem[a];
        checks++;
        if (rdata !== rdata_exp) begin
            failures++;
            $display("FAIL back_to_back rdata: got %h expected %h", rdata, rdata_exp);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] probe;
        @(negedge clk);
        probe = ld_exp;
        ld_data = ~ref_mem[probe];
        ld_stb = 1'b1;
        @(negedge clk);
        ld_stb = 1'b0;
        checks++;
        if (ld_addr !== ld_exp) begin
            failures++;
            $display("FAIL run_ignores_stb ld_addr: got %h expected %h", ld_addr, ld_exp);
        end
        access("run_ignores_stb_mem", 1'b1, 1'b0, {8'h00, probe}, 8'h00);
        cpustate = 2'b00;
        read = 1'b1;
        addr = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignores_read ready: got %b expected 0", ready);
            end
        end
        read = 1'b0;
        cpustate = 2'b10;
    endtask

    task automatic test_errors();
        logic [7:0] a;
        a = 8'($urandom);
        access("both_high", 1'b1, 1'b1, {8'h00, a}, ~ref_mem[a]);
        access("both_high_mem", 1'b1, 1'b0, {8'h00, a}, 8'h00);
        access("hi_addr_read", 1'b1, 1'b0, 16'h0105, 8'h00);
        access("err_sticky", 1'b0, 1'b1, 16'h0020, 8'h77);
    endtask

    task automatic test_mode_change_mid_access();
        int lat;
        @(negedge clk);
        read = 1'b1;
        addr = 16'h0020;
        @(negedge clk);
        read = 1'b0;
        cpustate = 2'b00;
        lat = 1;
        while (ready !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rdata_exp = ref_mem[8'h20];
        checks++;
        if (lat != LAT || rdata !== rdata_exp) begin
            failures++;
            $display("FAIL mode_change_mid_access: got lat=%0d rdata=%h expected lat=%0d rdata=%h",
                     lat, rdata, LAT, rdata_exp);
        end
        @(negedge clk);
        cpustate = 2'b10;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        read = 1'b1;
        addr = 16'h0030;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read = 1'b0;
        #1;
        checks++;
        if ({rdata, ready, ld_addr, err} !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_access outputs: got rdata=%h ready=%b ld_addr=%h err=%b expected all zero",
                     rdata, ready, ld_addr, err);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_access ready: got %b expected 0", ready);
            end
        end
        rst = 1'b1;
        rdata_exp = 8'h00;
        err_exp = 1'b0;
        ld_exp = 8'h00;
        access("ram_survives_reset", 1'b1, 1'b0, 16'h0020, 8'h00);
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_wrap();
        test_random_rw();
        test_back_to_back();
        test_ignored_inputs();
        test_errors();
        test_mode_change_mid_access();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Reset is asynchronous and active-low; the block has one clock.
REQ-002 clk  input  1  rising-edge system clock (clk_choose domain of the CPU).
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 cpustate  input  2  mode: 2'b01 program-load, 2'b10 run, others idle.
REQ-005 addr  input  16  CPU address bus (AR output).
REQ-006 wdata  input  8  CPU write data (CPU data_out).
REQ-007 read  input  1  CPU read request, level, sampled in IDLE.
REQ-008 write  input  1  CPU write request, level, sampled in IDLE.
REQ-009 rdata  output  8  read data to CPU data_in.
REQ-010 ready  output  1  one-cycle pulse marking access completion.
REQ-011 ld_data  input  8  switch data for program load.
REQ-012 ld_stb  input  1  one-cycle load strobe (debounced key).
REQ-013 ld_addr  output  8  next program-load address.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 Storage SHALL be 256 x 8 internal RAM indexed by addr[7:0] (run) or ld_addr (load).
REQ-016 FSM states SHALL be IDLE, ACC, WAIT (WAIT only with MEM_WAIT_EN), DONE.
REQ-017 In IDLE with cpustate=2'b10 and read or write high, the block SHALL latch addr[7:0], wdata, request type and go to ACC.
REQ-018 In ACC a write SHALL update mem[latched addr]; a read SHALL register mem[latched addr] into rdata; next state DONE (or WAIT).
REQ-019 In DONE ready SHALL be 1 for exactly one cycle, then IDLE; requests still high in IDLE start a new access.
REQ-020 Latency: request sampled in cycle N -> ready high in cycle N+2, rdata valid from N+2 and held until the next read completes.
REQ-021 read and write both high SHALL perform no memory access, set err, leave rdata unchanged, and still pulse ready.
REQ-022 addr[15:8] nonzero on an accepted request SHALL set err; the access proceeds on addr[7:0].
REQ-023 err SHALL stay 1 until reset.
REQ-024 In IDLE with cpustate=2'b01, each ld_stb SHALL write ld_data to mem[ld_addr] and increment ld_addr; 8'hFF wraps to 8'h00; ready stays 0.
REQ-025 ld_addr SHALL clear to 0 on the cycle cpustate enters 2'b01 from any other value, and hold otherwise.
REQ-026 read/write SHALL be ignored when cpustate is not 2'b10; ld_stb ignored when cpustate is not 2'b01.
REQ-027 A cpustate change during ACC/WAIT/DONE SHALL not abort the access; it completes with ready.

Reset
REQ-028 rst low SHALL force state IDLE, rdata=8'h00, ready=0, ld_addr=8'h00, err=0 immediately, regardless of clk.
REQ-029 RAM contents SHALL not be cleared by reset; reset mid-access SHALL drop the access without ready.

Configuration
REQ-030 With MEM_WAIT_EN defined, ACC SHALL go to WAIT for one cycle before DONE (ready at N+3); without it WAIT does not exist and ready is at N+2.

Verification
REQ-031 Load mode, ld_stb with ld_data 8'hA5,8'h3C -> mem[0]=A5, mem[1]=3C, ld_addr=2.
REQ-032 Run, write addr 16'h0010 data 8'h5A then read 16'h0010 -> ready at N+2 each, rdata=8'h5A.
REQ-033 256 load strobes after entering load -> ld_addr returns to 8'h00, mem[0] overwritten by strobe 257.
REQ-034 Run, read and write both high -> ready pulse, err=1, memory and rdata unchanged.
REQ-035 Read 16'h0105 -> err=1, rdata=mem[8'h05]; rst low mid-ACC -> ready stays 0, all outputs at reset values.
REQ-036 MEM_WAIT_EN defined, read request at cycle N -> ready exactly at N+3.
